// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a stable lock,
// retries on timeout, latches a fault after repeated failures.
module pll_reset_ctrl #(
    parameter int unsigned POR_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       fault_clear,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    localparam logic [2:0] RESET_PLL = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABILIZE = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    localparam int unsigned MAX_A =
        (POR_CYCLES > LOCK_TIMEOUT) ? POR_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_P =
        (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RTY_MAX  = 4'(MAX_RETRIES);

    logic [2:0]             state;
    logic [2:0]             state_d;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic [3:0]             retry_d;
    logic [7:0]             loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        retry_d = retry_count;
        loss_d  = loss_count;
        unique case (state)
            RESET_PLL: begin
                if (cnt == POR_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_count == RTY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_count + 1'b1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    if (loss_count != 8'hFF) begin
                        loss_d = loss_count + 1'b1;
                    end
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (fault_clear) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase
        // every phase measures its own duration from zero
        if (state_d != state) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            retry_count <= retry_d;
            loss_count  <= loss_d;
        end
    end

    assign pll_rst = (state == RESET_PLL) || (state == FAULT);
    assign sys_rst = (state != RUN);
    assign ready   = (state == RUN);
    assign fault   = (state == FAULT);

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed bring-up scenarios plus random lock
// activity, compared cycle by cycle with a phase/age reference model.
module tb_pll_reset_ctrl;

    localparam int POR  = 4;
    localparam int LT   = 20;
    localparam int ST   = 8;
    localparam int MR   = 2;
    localparam int SYNC = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       fault_clear = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pll_reset_ctrl #(
        .POR_CYCLES(POR),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES(MR),
        .SYNC_STAGES(SYNC)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .fault_clear(fault_clear),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .fault(fault),
        .retry_count(retry_count),
        .loss_count(loss_count)
    );

    always #5 refclk = ~refclk;

    typedef enum {P_POR, P_WAIT, P_STAB, P_RUN, P_FAULT} phase_t;
    phase_t ph = P_POR;
    int     age = 0;
    int     m_retry = 0;
    int     m_loss = 0;
    bit     lk_q[$];

    // Reference: a phase plus how long it has lasted; lock seen SYNC edges late.
    function automatic void model_edge();
        bit     ls;
        phase_t nx;
        if (rst) begin
            ph = P_POR;
            age = 0;
            m_retry = 0;
            m_loss = 0;
            lk_q = {};
            for (int i = 0; i < SYNC; i++) lk_q.push_back(1'b0);
            return;
        end
        ls = lk_q.pop_front();
        lk_q.push_back(pll_locked);
        nx = ph;
        case (ph)
            P_POR: if (age + 1 >= POR) nx = P_WAIT;
            P_WAIT: begin
                if (ls) nx = P_STAB;
                else if (age + 1 >= LT) begin
                    if (m_retry == MR) nx = P_FAULT;
                    else begin
                        m_retry++;
                        nx = P_POR;
                    end
                end
            end
            P_STAB: begin
                if (!ls) nx = P_WAIT;
                else if (age + 1 >= ST) begin
                    nx = P_RUN;
                    m_retry = 0;
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    nx = P_POR;
                end
            end
            P_FAULT: begin
                if (fault_clear) begin
                    nx = P_POR;
                    m_retry = 0;
                end
            end
            default: nx = P_POR;
        endcase
        age = (nx == ph) ? age + 1 : 0;
        ph = nx;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        cyc++;
        chk("pll_rst", int'(pll_rst), int'(ph == P_POR || ph == P_FAULT));
        chk("sys_rst", int'(sys_rst), int'(ph != P_RUN));
        chk("ready", int'(ready), int'(ph == P_RUN));
        chk("fault", int'(fault), int'(ph == P_FAULT));
        chk("retry_count", int'(retry_count), m_retry);
        chk("loss_count", int'(loss_count), m_loss);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int n;
        int prev;
        int d;

        // reset state
        pll_locked = 1'b0;
        do_reset();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_loss", int'(loss_count), 0);

        // 1: locked throughout
        pll_locked = 1'b1;
        while (!ready && cyc < 100) step();
        chk("c1_ready_cycle", cyc, 13);
        chk("c1_retry", int'(retry_count), 0);

        // 2: never locks
        pll_locked = 1'b0;
        do_reset();
        n = 1;
        prev = 1;
        while (!fault && cyc < 200) begin
            step();
            if (pll_rst && prev == 0 && !fault) n++;
            prev = int'(pll_rst);
        end
        chk("c2_fault_cycle", cyc, 72);
        chk("c2_pll_rst_pulses", n, 3);
        repeat (15) step();
        chk("c2_fault_hold", int'(fault), 1);
        chk("c2_sys_rst", int'(sys_rst), 1);

        // 3: fault_clear then lock
        fault_clear = 1'b1;
        pll_locked = 1'b1;
        step();
        fault_clear = 1'b0;
        chk("c3_fault_exit", int'(fault), 0);
        chk("c3_retry_clr", int'(retry_count), 0);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        chk("c3_ready_delay", n, 13);

        // 4: lock glitch during STABILIZE
        do_reset();
        pll_locked = 1'b1;
        d = $urandom_range(5, 9);
        while (cyc < d) step();
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        while (!ready && cyc < 200) step();
        chk("c4_ready_cycle", cyc, d + 14);
        chk("c4_retry", int'(retry_count), 0);

        // 5: repeated lock losses in RUN
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 4)) step();
            pll_locked = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (ready && n < 10);
            pll_locked = 1'b1;
            if (i == 0) begin
                chk("c5_ready_fall", n, 3);
                chk("c5_loss1", int'(loss_count), 1);
                n = 0;
                while (pll_rst && n < 20) begin
                    n++;
                    step();
                end
                chk("c5_pll_rst_len", n, POR);
            end
            n = 0;
            while (!ready && n < 100) begin
                step();
                n++;
            end
            chk("c5_relock", int'(ready), 1);
        end
        chk("c5_loss_sat", int'(loss_count), 255);

        // 6: rst during STABILIZE clears everything
        pll_locked = 1'b0;
        n = 0;
        while (ready && n < 10) begin
            step();
            n++;
        end
        pll_locked = 1'b1;
        repeat (6) step();
        rst = 1'b1;
        step();
        chk("c6_pll_rst", int'(pll_rst), 1);
        chk("c6_sys_rst", int'(sys_rst), 1);
        chk("c6_ready", int'(ready), 0);
        chk("c6_fault", int'(fault), 0);
        chk("c6_retry", int'(retry_count), 0);
        chk("c6_loss", int'(loss_count), 0);
        rst = 1'b0;
        cyc = 0;

        // random lock activity with occasional fault_clear
        for (int s = 0; s < 40; s++) begin
            pll_locked = ($urandom_range(0, 2) != 0);
            repeat ($urandom_range(1, 45)) begin
                fault_clear = ($urandom_range(0, 15) == 0);
                step();
            end
            fault_clear = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
